// File: rtl/hazard_controller_if.sv
// hazard_controller_if
//   Bundles every pipeline-facing signal of the hazard controller.
//   Ports (all carried as interface members):
//     RS1_D, RS2_D            Decode source registers
//     RS1_E, RS2_E, RD_E      Execute source/destination registers
//     Result_Src_Sel_E        2'b01 marks a load in Execute
//     PC_Src_E                branch taken / jump resolved in Execute
//     RD_M, RD_W              Memory / Writeback destination registers
//     REG_W_En_M, REG_W_En_W  Memory / Writeback register write enables
//     MEM_Req_M, MEM_Ready_M  data-memory request / completion
//     Stall_F/D/E/M           hold PC, IF/ID, ID/EX, EX/MEM
//     Flush_D, Flush_E        insert NOP into IF/ID, ID/EX
//     Forward_A_E/B_E         Execute operand forwarding selects
//     Mem_Err                 sticky watchdog error
//     Stall_Cycles/Flush_Cycles  saturating performance counters
//   modport slave  : the hazard controller
//   modport master : the pipeline driving it
interface hazard_controller_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       RS1_D;
  logic [4:0]       RS2_D;
  logic [4:0]       RS1_E;
  logic [4:0]       RS2_E;
  logic [4:0]       RD_E;
  logic [1:0]       Result_Src_Sel_E;
  logic             PC_Src_E;
  logic [4:0]       RD_M;
  logic [4:0]       RD_W;
  logic             REG_W_En_M;
  logic             REG_W_En_W;
  logic             MEM_Req_M;
  logic             MEM_Ready_M;
  logic             Stall_F;
  logic             Stall_D;
  logic             Stall_E;
  logic             Stall_M;
  logic             Flush_D;
  logic             Flush_E;
  logic [1:0]       Forward_A_E;
  logic [1:0]       Forward_B_E;
  logic             Mem_Err;
  logic [CNT_W-1:0] Stall_Cycles;
  logic [CNT_W-1:0] Flush_Cycles;

  modport slave (
    input  RS1_D, RS2_D, RS1_E, RS2_E, RD_E, Result_Src_Sel_E, PC_Src_E,
           RD_M, RD_W, REG_W_En_M, REG_W_En_W, MEM_Req_M, MEM_Ready_M,
    output Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E,
           Forward_A_E, Forward_B_E, Mem_Err, Stall_Cycles, Flush_Cycles
  );

  modport master (
    output RS1_D, RS2_D, RS1_E, RS2_E, RD_E, Result_Src_Sel_E, PC_Src_E,
           RD_M, RD_W, REG_W_En_M, REG_W_En_W, MEM_Req_M, MEM_Ready_M,
    input  Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E,
           Forward_A_E, Forward_B_E, Mem_Err, Stall_Cycles, Flush_Cycles
  );
endinterface

// File: rtl/hazard_controller.sv
// hazard_controller
//   Hazard and sequencing controller for the five-stage RV32i pipeline:
//   operand forwarding, load-use bubbles, branch flushes, a freeze FSM for
//   multi-cycle data-memory accesses with a watchdog, and saturating
//   stall/flush cycle counters.
//   Ports:
//     CLK  clock, rising edge
//     RST  synchronous active-low reset
//     hz   hazard_controller_if.slave (see interface file for members)
//   Parameters:
//     MEM_TIMEOUT  consecutive wait cycles before ERR (0 disables watchdog)
//     CNT_W        performance counter width
module hazard_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic                CLK,
  input logic                RST,
  hazard_controller_if.slave hz
);

  // A zero timeout still needs a 1-bit counter to keep widths legal.
  localparam int WCW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WCW-1:0] WAIT_LAST =
    (MEM_TIMEOUT > 0) ? WCW'(MEM_TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t           state;
  logic [WCW-1:0]   wait_cnt;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  logic       mem_wait;
  logic       load_use;
  logic       timeout_hit;
  logic       s_f, s_d, s_e, s_m;
  logic       f_d, f_e;
  logic       branch_flush;
  logic [1:0] fwd_a, fwd_b;

  // Memory stage result wins over Writeback since it is the newer value.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       we_m,
    input logic [4:0] rd_m,
    input logic       we_w,
    input logic [4:0] rd_w
  );
    if (we_m && (rd_m != 5'd0) && (rd_m == rs))
      return 2'b10;
    else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign mem_wait = hz.MEM_Req_M && !hz.MEM_Ready_M;

  assign load_use = (hz.Result_Src_Sel_E == 2'b01) && (hz.RD_E != 5'd0) &&
                    ((hz.RD_E == hz.RS1_D) || (hz.RD_E == hz.RS2_D));

  // Checked in RUN as well so a timeout of 1 trips on the first wait cycle.
  assign timeout_hit = (MEM_TIMEOUT != 0) && mem_wait && (wait_cnt == WAIT_LAST);

  // Output priority: ERR / memory freeze, then branch flush, then load-use.
  // A branch seen during a freeze stays in the frozen ID/EX register and is
  // flushed once the freeze lifts.
  always_comb begin
    s_f          = 1'b0;
    s_d          = 1'b0;
    s_e          = 1'b0;
    s_m          = 1'b0;
    f_d          = 1'b0;
    f_e          = 1'b0;
    branch_flush = 1'b0;
    fwd_a        = 2'b00;
    fwd_b        = 2'b00;
    if (RST) begin
      fwd_a = fwd_sel(hz.RS1_E, hz.REG_W_En_M, hz.RD_M, hz.REG_W_En_W, hz.RD_W);
      fwd_b = fwd_sel(hz.RS2_E, hz.REG_W_En_M, hz.RD_M, hz.REG_W_En_W, hz.RD_W);
      if ((state == ERR) || mem_wait) begin
        s_f = 1'b1;
        s_d = 1'b1;
        s_e = 1'b1;
        s_m = 1'b1;
      end else if (hz.PC_Src_E) begin
        f_d          = 1'b1;
        f_e          = 1'b1;
        branch_flush = 1'b1;
      end else if (load_use) begin
        s_f = 1'b1;
        s_d = 1'b1;
        f_e = 1'b1;
      end
    end
  end

  // Freeze FSM, watchdog counter, sticky error and performance counters.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (mem_wait) begin
        if (wait_cnt != '1)
          wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      case (state)
        RUN: begin
          if (timeout_hit) begin
            state   <= ERR;
            mem_err <= 1'b1;
          end else if (mem_wait) begin
            state <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (timeout_hit) begin
            state   <= ERR;
            mem_err <= 1'b1;
          end else if (!mem_wait) begin
            state <= RUN;
          end
        end
        ERR: state <= ERR;
        default: state <= RUN;
      endcase

      if ((s_f || s_d || s_e || s_m) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (branch_flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign hz.Stall_F      = s_f;
  assign hz.Stall_D      = s_d;
  assign hz.Stall_E      = s_e;
  assign hz.Stall_M      = s_m;
  assign hz.Flush_D      = f_d;
  assign hz.Flush_E      = f_e;
  assign hz.Forward_A_E  = fwd_a;
  assign hz.Forward_B_E  = fwd_b;
  assign hz.Mem_Err      = mem_err;
  assign hz.Stall_Cycles = stall_cnt;
  assign hz.Flush_Cycles = flush_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller
//   Directed bench for hazard_controller with MEM_TIMEOUT=4 and 4-bit
//   counters so the watchdog and counter saturation are reachable quickly.
//   Inputs change just after the falling edge; combinational outputs are
//   checked 1 ns later, registered outputs 1 ns after the rising edge.
module tb_hazard_controller;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    logic [4:0] rs1_e;
    logic [4:0] rs2_e;
    logic [4:0] rd_e;
    logic [1:0] rsrc;
    logic       pcsrc;
    logic [4:0] rd_m;
    logic [4:0] rd_w;
    logic       wm;
    logic       ww;
    logic       req;
    logic       rdy;
  } vec_t;

  logic CLK;
  logic RST;
  int   errors = 0;
  int   checks = 0;

  hazard_controller_if #(.CNT_W(CNT_W)) hz ();

  hazard_controller #(
    .MEM_TIMEOUT(4),
    .CNT_W      (CNT_W)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .hz (hz)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E}
  function automatic logic [5:0] ctl_vec();
    return {hz.Stall_F, hz.Stall_D, hz.Stall_E, hz.Stall_M, hz.Flush_D, hz.Flush_E};
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(negedge CLK);
    hz.RS1_D            = v.rs1_d;
    hz.RS2_D            = v.rs2_d;
    hz.RS1_E            = v.rs1_e;
    hz.RS2_E            = v.rs2_e;
    hz.RD_E             = v.rd_e;
    hz.Result_Src_Sel_E = v.rsrc;
    hz.PC_Src_E         = v.pcsrc;
    hz.RD_M             = v.rd_m;
    hz.RD_W             = v.rd_w;
    hz.REG_W_En_M       = v.wm;
    hz.REG_W_En_W       = v.ww;
    hz.MEM_Req_M        = v.req;
    hz.MEM_Ready_M      = v.rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    vec_t v;

    // Reset with inputs that would otherwise forward, freeze and flush.
    RST = 1'b0;
    v = '0;
    v.rs1_e = 5'd5; v.rd_m = 5'd5; v.wm = 1'b1;
    v.req = 1'b1; v.pcsrc = 1'b1;
    applyStimulus(v);
    checkOutput("rst_ctl", ctl_vec(), 6'b000000);
    checkOutput("rst_fwd_a", hz.Forward_A_E, 2'b00);
    tick();
    checkOutput("rst_err", hz.Mem_Err, 1'b0);
    checkOutput("rst_stall_cnt", hz.Stall_Cycles, 4'd0);
    checkOutput("rst_flush_cnt", hz.Flush_Cycles, 4'd0);

    // Forwarding priority.
    RST = 1'b1;
    v = '0;
    v.rd_m = 5'd5; v.rd_w = 5'd5; v.rs1_e = 5'd5; v.rs2_e = 5'd7;
    v.wm = 1'b1; v.ww = 1'b1;
    applyStimulus(v);
    checkOutput("fwd_a_mem", hz.Forward_A_E, 2'b10);
    checkOutput("fwd_b_none", hz.Forward_B_E, 2'b00);
    checkOutput("fwd_ctl", ctl_vec(), 6'b000000);
    v.wm = 1'b0;
    applyStimulus(v);
    checkOutput("fwd_a_wb", hz.Forward_A_E, 2'b01);
    v.rs1_e = 5'd0;
    applyStimulus(v);
    checkOutput("fwd_a_x0", hz.Forward_A_E, 2'b00);
    v = '0;
    v.rd_m = 5'd7; v.rd_w = 5'd9; v.rs2_e = 5'd9; v.wm = 1'b1; v.ww = 1'b1;
    applyStimulus(v);
    checkOutput("fwd_b_wb", hz.Forward_B_E, 2'b01);
    v.rd_w = 5'd0; v.rs2_e = 5'd0; v.rd_m = 5'd0;
    applyStimulus(v);
    checkOutput("fwd_b_x0", hz.Forward_B_E, 2'b00);

    // Load-use: lw x3 in Execute, add x4,x3,x1 in Decode.
    v = '0;
    v.rsrc = 2'b01; v.rd_e = 5'd3; v.rs1_d = 5'd3; v.rs2_d = 5'd1;
    applyStimulus(v);
    checkOutput("lu_ctl", ctl_vec(), 6'b110001);
    tick();
    applyStimulus('0);
    checkOutput("lu_after_ctl", ctl_vec(), 6'b000000);
    checkOutput("lu_stall_cnt", hz.Stall_Cycles, 4'd1);
    checkOutput("lu_flush_cnt", hz.Flush_Cycles, 4'd0);
    v.rd_e = 5'd0; v.rs1_d = 5'd0;
    applyStimulus(v);
    checkOutput("lu_x0_ctl", ctl_vec(), 6'b000000);
    v.rd_e = 5'd3; v.rs1_d = 5'd0; v.rs2_d = 5'd3; v.rsrc = 2'b00;
    applyStimulus(v);
    checkOutput("lu_not_load_ctl", ctl_vec(), 6'b000000);

    // Branch resolved while a load-use hazard is also present.
    v = '0;
    v.rsrc = 2'b01; v.rd_e = 5'd3; v.rs2_d = 5'd3; v.pcsrc = 1'b1;
    applyStimulus(v);
    checkOutput("br_ctl", ctl_vec(), 6'b000011);
    tick();
    applyStimulus('0);
    checkOutput("br_flush_cnt", hz.Flush_Cycles, 4'd1);
    checkOutput("br_stall_cnt", hz.Stall_Cycles, 4'd1);

    // Three wait cycles with a branch pending, then completion.
    v = '0;
    v.req = 1'b1; v.pcsrc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(v);
      checkOutput($sformatf("mw_ctl_%0d", i), ctl_vec(), 6'b111100);
      tick();
    end
    v.rdy = 1'b1;
    applyStimulus(v);
    checkOutput("mw_ready_ctl", ctl_vec(), 6'b000011);
    tick();
    checkOutput("mw_stall_cnt", hz.Stall_Cycles, 4'd4);
    checkOutput("mw_flush_cnt", hz.Flush_Cycles, 4'd2);
    checkOutput("mw_err", hz.Mem_Err, 1'b0);

    // Access completing in its first cycle costs nothing.
    v = '0;
    v.req = 1'b1; v.rdy = 1'b1;
    applyStimulus(v);
    checkOutput("mw0_ctl", ctl_vec(), 6'b000000);
    tick();
    checkOutput("mw0_stall_cnt", hz.Stall_Cycles, 4'd4);

    // Reset in the middle of a wait with Wait_Cnt=2.
    v = '0;
    v.req = 1'b1;
    applyStimulus(v);
    tick();
    applyStimulus(v);
    tick();
    checkOutput("rmw_stall_cnt_pre", hz.Stall_Cycles, 4'd6);
    RST = 1'b0;
    applyStimulus(v);
    checkOutput("rmw_ctl_in_rst", ctl_vec(), 6'b000000);
    tick();
    RST = 1'b1;
    applyStimulus('0);
    checkOutput("rmw_ctl", ctl_vec(), 6'b000000);
    checkOutput("rmw_stall_cnt", hz.Stall_Cycles, 4'd0);
    checkOutput("rmw_flush_cnt", hz.Flush_Cycles, 4'd0);
    checkOutput("rmw_err", hz.Mem_Err, 1'b0);

    // Watchdog: memory never ready, error after the fourth wait cycle.
    v = '0;
    v.req = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(v);
      checkOutput($sformatf("wd_ctl_%0d", i), ctl_vec(), 6'b111100);
      tick();
      checkOutput($sformatf("wd_err_%0d", i), hz.Mem_Err, (i == 4) ? 1'b1 : 1'b0);
    end
    checkOutput("wd_stall_cnt", hz.Stall_Cycles, 4'd4);

    // ERR keeps the pipeline frozen even after the request drops.
    v = '0;
    v.pcsrc = 1'b1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(v);
      tick();
    end
    checkOutput("err_ctl", ctl_vec(), 6'b111100);
    checkOutput("err_sticky", hz.Mem_Err, 1'b1);
    checkOutput("err_stall_sat", hz.Stall_Cycles, 4'hF);
    checkOutput("err_flush_cnt", hz.Flush_Cycles, 4'd0);

    // One reset edge leaves ERR and returns to RUN.
    RST = 1'b0;
    applyStimulus('0);
    tick();
    RST = 1'b1;
    applyStimulus(v);
    checkOutput("wdr_err", hz.Mem_Err, 1'b0);
    checkOutput("wdr_ctl_run", ctl_vec(), 6'b000011);
    checkOutput("wdr_stall_cnt", hz.Stall_Cycles, 4'd0);
    tick();
    checkOutput("wdr_flush_cnt", hz.Flush_Cycles, 4'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
